demux_burst_scheduler: RTL and testbench

//  Sequences a 1:4 demultiplexer datapath. Accepts one valid/ready input stream and

---
 rtl/demux_burst_scheduler.sv | 144 ++++++++++++++
 tb/tb_demux_burst_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_burst_scheduler.sv
// Burst scheduler for a 1:4 demux: grants a single valid/ready producer to one of
// four consumers for BURST_LEN beats, chosen round-robin over a mask or by a fixed select.
`timescale 1ns/1ps
module demux_burst_scheduler #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [1:0]        fixed_sel,
  input  logic [3:0]        ch_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              timeout_err
);

  localparam int BCW = $clog2(BURST_LEN) + 1;
  localparam int SCW = $clog2(TIMEOUT) + 1;
  localparam logic [BCW-1:0] BEAT_LAST  = BCW'(BURST_LEN - 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sel_q, sel_d;
  logic [1:0]     rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           busy_q, busy_d;
  logic           tout_q, tout_d;

  logic           rr_hit;
  logic [1:0]     rr_target;
  logic [1:0]     rr_cand;
  logic [1:0]     target;
  logic           target_ok;
  logic           xfer;

  // Search starts one past the last served channel, so the last served one is tried last.
  always_comb begin
    rr_hit    = 1'b0;
    rr_target = rr_ptr_q;
    rr_cand   = rr_ptr_q;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = rr_ptr_q + 2'(k);
      if (!rr_hit && ch_mask[rr_cand]) begin
        rr_hit    = 1'b1;
        rr_target = rr_cand;
      end
    end
  end

  assign target    = mode ? fixed_sel : rr_target;
  assign target_ok = mode | rr_hit;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 4'b0000;
    if (state_q == ST_BURST) begin
      in_ready         = out_ready[sel_q];
      out_valid[sel_q] = in_valid;
    end
  end

  assign out_data    = in_data;
  assign xfer        = in_valid & in_ready;
  assign sel         = sel_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    busy_d      = busy_q;
    tout_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && in_valid && target_ok) begin
          state_d     = ST_BURST;
          sel_d       = target;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
          busy_d      = 1'b1;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          beat_cnt_d  = beat_cnt_q + BCW'(1);
          stall_cnt_d = '0;
          if (beat_cnt_q == BEAT_LAST) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            rr_ptr_d = sel_q;
          end
        end else if (stall_cnt_q == STALL_LAST) begin
          // Abort a stalled burst so one dead consumer cannot hold the producer forever.
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          tout_d   = 1'b1;
          rr_ptr_d = sel_q;
        end else begin
          stall_cnt_d = stall_cnt_q + SCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 2'd0;
      rr_ptr_q    <= 2'd3;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      busy_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      busy_q      <= busy_d;
      tout_q      <= tout_d;
    end
  end

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Directed bench for demux_burst_scheduler: beats are scoreboarded by channel and data
// order, with per-cycle protocol checks and directed timeout/enable/reset scenarios.
`timescale 1ns/1ps
module tb_demux_burst_scheduler;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 16;

  logic              clk;
  logic              rst;
  logic              en;
  logic              mode;
  logic [1:0]        fixed_sel;
  logic [3:0]        ch_mask;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_ready;
  logic [1:0]        sel;
  logic              busy;
  logic              timeout_err;

  demux_burst_scheduler #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fixed_sel(fixed_sel),
    .ch_mask(ch_mask), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .sel(sel),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        ch;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t             exp_q[$];
  int                xfer_log[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_tick   = 0;
  int                beats_in_burst = 0;
  logic              busy_prev = 1'b0;
  logic [3:0]        ov_accum  = 4'b0000;
  logic [DATA_W-1:0] data_ctr  = '0;
  logic [DATA_W-1:0] push_ctr  = '0;
  int                t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_beat(input logic [1:0] ch);
    beat_t b;
    b.ch   = ch;
    b.data = push_ctr;
    exp_q.push_back(b);
    push_ctr = push_ctr + 1'b1;
  endtask

  task automatic push_burst(input logic [1:0] ch);
    for (int i = 0; i < BURST_LEN; i++) push_beat(ch);
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic tick();
    logic       did_xfer;
    logic [3:0] ov_e;
    beat_t      e;
    did_xfer = 1'b0;
    #1;
    n_tick++;
    ov_accum = ov_accum | out_valid;
    check("onehot", 32'($countones(out_valid) <= 1), 1);
    check("out_data_pass", out_data, in_data);
    if (busy && !busy_prev) beats_in_burst = 0;
    if (!busy && busy_prev && !timeout_err && !rst)
      check("burst_len", beats_in_burst, BURST_LEN);
    busy_prev = busy;
    if (!busy) begin
      check("idle_in_ready", in_ready, 0);
      check("idle_out_valid", out_valid, 0);
    end else if (exp_q.size() > 0) begin
      ov_e = in_valid ? (4'b0001 << exp_q[0].ch) : 4'b0000;
      check("burst_in_ready", in_ready, out_ready[exp_q[0].ch]);
      check("burst_out_valid", out_valid, ov_e);
      check("burst_sel", sel, exp_q[0].ch);
    end
    if (in_valid && in_ready) begin
      did_xfer = 1'b1;
      beats_in_burst++;
      xfer_log.push_back(n_tick);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat_ch", sel, e.ch);
        check("beat_data", out_data, e.data);
      end
    end
    @(negedge clk);
    if (did_xfer) begin
      data_ctr = data_ctr + 1'b1;
      in_data  = data_ctr;
    end
  endtask

  task automatic run(input int budget, input bit toggle2);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      if (toggle2) out_ready[2] = ~out_ready[2];
      tick();
      b++;
    end
    check("run_drained", exp_q.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, required finish before 50000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; fixed_sel = 2'd0; ch_mask = 4'hF;
    in_valid = 1'b1; in_data = '0; out_ready = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_timeout_err", timeout_err, 0);

    // Round-robin over all channels, continuous traffic.
    rst = 1'b0;
    xfer_log.delete();
    t0 = n_tick;
    push_burst(0); push_burst(1); push_burst(2); push_burst(3); push_burst(0);
    run(60, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 5 * BURST_LEN && k < xfer_log.size(); k++)
      check("t1_beat_timing", xfer_log[k] - t0, 2 + k + k / BURST_LEN);
    check("t1_beat_count", xfer_log.size(), 5 * BURST_LEN);

    // Sparse mask: only channels 1 and 3 eligible.
    ch_mask = 4'b1010;
    ov_accum = 4'b0000;
    push_burst(1); push_burst(3); push_burst(1); push_burst(3);
    in_valid = 1'b1;
    run(60, 1'b0);
    in_valid = 1'b0;
    check("t2_ch0_ch2_quiet", ov_accum & 4'b0101, 0);
    check("t2_ch1_ch3_used", ov_accum & 4'b1010, 4'b1010);

    // Fixed select with a toggling consumer.
    mode = 1'b1; fixed_sel = 2'd2; ch_mask = 4'hF;
    push_burst(2); push_burst(2);
    in_valid = 1'b1;
    run(80, 1'b1);
    in_valid = 1'b0;
    out_ready = 4'hF;
    check("t3_sel_fixed", sel, 2);

    // Timeout on a stuck consumer, then round-robin resumes after it.
    mode = 1'b0; ch_mask = 4'b0010; out_ready = 4'b0000; in_valid = 1'b1;
    tick();
    check("t4_grant_busy", busy, 1);
    check("t4_grant_sel", sel, 1);
    repeat (TIMEOUT - 1) begin
      tick();
      check("t4_stall_no_err", timeout_err, 0);
      check("t4_stall_busy", busy, 1);
      check("t4_stall_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    ch_mask = 4'hF;
    tick();
    check("t4_err_pulse", timeout_err, 1);
    check("t4_err_idle", busy, 0);
    check("t4_err_rdy", in_ready, 0);
    tick();
    check("t4_err_one_cycle", timeout_err, 0);
    out_ready = 4'hF;
    push_burst(2);
    in_valid = 1'b1;
    run(20, 1'b0);
    in_valid = 1'b0;

    // Dropping en mid-burst lets the burst finish, then no new grant.
    push_burst(3);
    en = 1'b1; in_valid = 1'b1;
    tick(); tick(); tick();
    check("t5_two_beats", exp_q.size(), BURST_LEN - 2);
    en = 1'b0;
    tick(); tick();
    check("t5_burst_done", exp_q.size(), 0);
    check("t5_idle", busy, 0);
    repeat (3) begin
      tick();
      check("t5_stay_idle", busy, 0);
      check("t5_no_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    en = 1'b1;

    // Reset mid-burst after one beat.
    ch_mask = 4'b0100;
    push_beat(2);
    in_valid = 1'b1;
    tick(); tick();
    check("t6_one_beat", exp_q.size(), 0);
    check("t6_mid_busy", busy, 1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_sel", sel, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_no_err", timeout_err, 0);
    busy_prev = 1'b0;
    rst = 1'b0;
    ch_mask = 4'hF;
    push_burst(0);
    run(20, 1'b0);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
